// File: rtl/tq_pkg.sv
// Shared constants and row-order tables for the 4x4 transform permutation scheduler.
package tq_pkg;
    localparam int COEF_W = 28;
    localparam int ROWS   = 4;

    typedef logic [1:0] row_t;

    // Entry i is the stored row emitted at read index i.
    localparam logic [ROWS-1:0][1:0] PERM_ORDER = {2'd3, 2'd1, 2'd2, 2'd0};
    localparam logic [ROWS-1:0][1:0] NAT_ORDER  = {2'd3, 2'd2, 2'd1, 2'd0};

    function automatic row_t order_row(input logic bypass, input row_t idx);
        return bypass ? NAT_ORDER[idx] : PERM_ORDER[idx];
    endfunction
endpackage

// File: rtl/perm4_sched_if.sv
// Row-in / row-out handshake bundle for perm4_sched.
interface perm4_sched_if #(parameter int COEF_W = tq_pkg::COEF_W);
    logic                     i_valid;
    logic                     i_ready;
    logic                     i_bypass;
    logic signed [COEF_W-1:0] i_0, i_1, i_2, i_3;
    logic                     o_valid;
    logic                     o_ack;
    logic signed [COEF_W-1:0] o_0, o_1, o_2, o_3;
    logic                     o_last;
    logic                     o_busy;

    modport master (
        output i_valid, i_bypass, i_0, i_1, i_2, i_3, o_ack,
        input  i_ready, o_valid, o_0, o_1, o_2, o_3, o_last, o_busy
    );
    modport slave (
        input  i_valid, i_bypass, i_0, i_1, i_2, i_3, o_ack,
        output i_ready, o_valid, o_0, o_1, o_2, o_3, o_last, o_busy
    );
endinterface

// File: rtl/perm4_bank.sv
// One ping-pong bank: 4 rows x 4 coefficients, synchronous write, combinational read.
module perm4_bank
    import tq_pkg::*;
#(
    parameter int COEF_W = tq_pkg::COEF_W
) (
    input  logic                         clk,
    input  logic                         we,
    input  row_t                         wrow,
    input  logic [ROWS-1:0][COEF_W-1:0]  wdata,
    input  row_t                         rrow,
    output logic [ROWS-1:0][COEF_W-1:0]  rdata
);
    logic [ROWS-1:0][COEF_W-1:0] mem [ROWS];

    // Storage is deliberately unreset; the full flags in the scheduler gate visibility.
    always_ff @(posedge clk) begin
        if (we) mem[wrow] <= wdata;
    end

    assign rdata = mem[rrow];
endmodule

// File: rtl/perm4_sched.sv
// Ping-pong row buffer that re-emits each 4-row block in 0,2,1,3 or natural order.
module perm4_sched
    import tq_pkg::*;
#(
    parameter int COEF_W = tq_pkg::COEF_W
) (
    input  logic          clk,
    input  logic          rst_n,
    perm4_sched_if.slave  bus
);
    logic                         wr_bank, rd_bank;
    row_t                         wr_row, rd_idx;
    logic [1:0]                   bank_full, byp;
    logic [1:0]                   full_set, full_clr;
    logic                         in_fire, out_fire, out_valid;
    row_t                         rrow;
    logic [ROWS-1:0][COEF_W-1:0]  wdata;
    logic [ROWS-1:0][COEF_W-1:0]  rdata [2];
    logic [ROWS-1:0][COEF_W-1:0]  rsel;

    assign bus.i_ready = !bank_full[wr_bank];
    assign out_valid   = bank_full[rd_bank];
    assign in_fire     = bus.i_valid && !bank_full[wr_bank];
    assign out_fire    = out_valid && bus.o_ack;

    assign wdata = {bus.i_3, bus.i_2, bus.i_1, bus.i_0};
    assign rrow  = order_row(byp[rd_bank], rd_idx);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        perm4_bank #(.COEF_W(COEF_W)) u_bank (
            .clk   (clk),
            .we    (in_fire && (wr_bank == 1'(b))),
            .wrow  (wr_row),
            .wdata (wdata),
            .rrow  (rrow),
            .rdata (rdata[b])
        );
    end

    assign rsel = rdata[rd_bank];

    assign bus.o_valid = out_valid;
    assign bus.o_last  = out_valid && (rd_idx == 2'd3);
    assign bus.o_0     = out_valid ? $signed(rsel[0]) : '0;
    assign bus.o_1     = out_valid ? $signed(rsel[1]) : '0;
    assign bus.o_2     = out_valid ? $signed(rsel[2]) : '0;
    assign bus.o_3     = out_valid ? $signed(rsel[3]) : '0;
    assign bus.o_busy  = (|bank_full) || (wr_row != 2'd0);

    // Write bank is never full and read bank is always full, so set and clear never collide.
    always_comb begin
        full_set = '0;
        full_clr = '0;
        if (in_fire && wr_row == 2'd3)  full_set[wr_bank] = 1'b1;
        if (out_fire && rd_idx == 2'd3) full_clr[rd_bank] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_bank   <= 1'b0;
            wr_row    <= 2'd0;
            rd_bank   <= 1'b0;
            rd_idx    <= 2'd0;
            bank_full <= 2'b00;
            byp       <= 2'b00;
        end else begin
            bank_full <= (bank_full & ~full_clr) | full_set;
            if (in_fire) begin
                wr_row <= wr_row + 2'd1;
                if (wr_row == 2'd0) byp[wr_bank] <= bus.i_bypass;
                if (wr_row == 2'd3) wr_bank <= ~wr_bank;
            end
            if (out_fire) begin
                rd_idx <= rd_idx + 2'd1;
                if (rd_idx == 2'd3) rd_bank <= ~rd_bank;
            end
        end
    end
endmodule

// File: doc/perm4_sched.md
PERM4_SCHED -- requirements
Module: perm4_sched

Interface
REQ-001 Parameter COEF_W, default 28, signed coefficient width.
REQ-002 Parameter ROWS, fixed 4, rows per 4x4 transform block.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 i_valid  input  1  input row valid.
REQ-006 i_ready  output  1  block can accept an input row.
REQ-007 i_bypass  input  1  1 = natural row order, 0 = permuted order; sampled with row 0 only.
REQ-008 i_0, i_1, i_2, i_3  input  COEF_W each, signed  four coefficients of one row.
REQ-009 o_valid  output  1  output row valid.
REQ-010 o_ack  input  1  downstream accepts the output row.
REQ-011 o_0, o_1, o_2, o_3  output  COEF_W each, signed  four coefficients of the emitted row.
REQ-012 o_last  output  1  high with the 4th emitted row of a block.
REQ-013 o_busy  output  1  high when either bank holds data or is partially written.

Function
REQ-014 Input beat accepted when i_valid && i_ready; output beat completed when o_valid && o_ack.
REQ-015 Two banks (ping-pong), each storing 4 rows plus one bypass flag.
REQ-016 Write side: wr_bank, wr_row 0..3; accepted row goes to bank[wr_bank] row wr_row, then wr_row increments; on row 3, bank_full[wr_bank] is set, wr_row wraps to 0 and wr_bank toggles.
REQ-017 i_ready = !bank_full[wr_bank]; a partially written bank never blocks input.
REQ-018 Read side: rd_bank, rd_idx 0..3; o_valid = bank_full[rd_bank].
REQ-019 Emitted row = row ORDER[rd_idx] of bank[rd_bank]; ORDER = 0,2,1,3 when stored bypass flag = 0, and 0,1,2,3 when it is 1.
REQ-020 Emitted row is not permuted within the row: o_k = stored column k.
REQ-021 On an output beat rd_idx increments; at rd_idx 3, bank_full[rd_bank] clears, rd_idx wraps to 0 and rd_bank toggles.
REQ-022 o_last = o_valid && rd_idx == 3.
REQ-023 Latency: if row 3 is accepted in cycle N, o_valid is high in cycle N+1 with the first row.
REQ-024 Sustained throughput is one row per cycle with o_ack held high. No bubbles occur between blocks.
REQ-025 Simultaneous write to one bank and read from the other in the same cycle is legal.
REQ-026 When a bank clears (full to empty) in a cycle, i_ready reflects the cleared state from the next cycle. No same-cycle bypass is made.
REQ-027 o_valid low with o_ack high has no effect. i_valid while i_ready is low is held off; data is not written.
REQ-028 o_0..o_3 are driven 0 whenever o_valid is low.
REQ-029 o_busy = bank_full[0] | bank_full[1] | (wr_row != 0).

Reset
REQ-030 While rst_n = 0 at a clock edge, the following are cleared: wr_bank, wr_row, rd_bank, rd_idx, bank_full and the bypass flags.
REQ-031 Outputs during and after reset: i_ready = 1, o_valid = 0, o_last = 0, o_busy = 0, o_0..o_3 = 0.
REQ-032 Reset mid-block discards all stored and partial rows. Row storage itself need not be reset.

Structure
REQ-033 Shared package tq_pkg holds COEF_W, ROWS and the ORDER tables (PERM_ORDER = 0,2,1,3; NAT_ORDER = 0,1,2,3).
REQ-034 One sub-module perm4_bank holds the 4-row x 4-coefficient storage with write port (row, data) and read port (row); it is instantiated twice.
REQ-035 All control (pointers, full flags, output mux) resides in perm4_sched.

Verification
REQ-036 Bench covers a permuted block. Stimulus: rows r0..r3 with i_k = 10*row+k, i_bypass = 0, o_ack = 1. Required response: outputs 0..3, 20..23, 10..13, 30..33, o_last on the 4th row, first o_valid one cycle after r3.
REQ-037 Bench covers a bypass block. Stimulus: same data with i_bypass = 1. Required response: outputs 0..3, 10..13, 20..23, 30..33.
REQ-038 Bench covers back-to-back blocks. Stimulus: 3 blocks streamed continuously with o_ack = 1. Required response: i_ready never low after the first block, 12 output rows with no gaps after the initial latency.
REQ-039 Bench covers backpressure. Stimulus: o_ack = 0 while 2 blocks are written. Required response: i_ready drops after 8 accepted rows; an o_ack pulse releases rows in order; the 9th row is accepted only after the first bank drains.
REQ-040 Bench covers reset mid-block. Stimulus: rst_n low for 1 cycle after 2 rows of a block. Required response: o_valid = 0, o_busy = 0, i_ready = 1; the next 4 rows form a fresh block output in correct order.
REQ-041 Bench covers signed extremes. Stimulus: a block with -2^27 and 2^27-1 values. Required response: values are passed through bit-exact.
